// File: rtl/exec_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : exec_pkg                                                     |
// | Description : Shared op-codes, forwarding selects and FSM state encoding   |
// |               for the multi-cycle execute stage.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package exec_pkg;

  // ALU operation codes (4-bit id_op field); 11..15 are reserved and yield 0
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOR = 4'd5;
  localparam logic [3:0] OP_SLT = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  // Forwarding source selects; code 3 behaves like code 0 (register data)
  localparam logic [1:0] FWD_REG     = 2'd0;
  localparam logic [1:0] FWD_MEM     = 2'd1;
  localparam logic [1:0] FWD_WB      = 2'd2;
  localparam logic [1:0] FWD_REG_ALT = 2'd3;

  // Multiply sequencing FSM
  typedef logic [1:0] exec_state_t;
  localparam exec_state_t ST_IDLE     = 2'd0;
  localparam exec_state_t ST_MUL_BUSY = 2'd1;
  localparam exec_state_t ST_MUL_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/exec_mul_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : exec_mul_iter                                                |
// | Description : Iterative shift-add multiplier, one multiplier bit per       |
// |               cycle, DATA_W steps. Returns the low DATA_W product bits,    |
// |               which are identical for signed and unsigned operands.        |
// |               Only built when EXEC_STAGE_MUL_EN is defined.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`ifdef EXEC_STAGE_MUL_EN
module exec_mul_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_freeze,
  input  logic              i_abort,
  input  logic [DATA_W-1:0] i_op_a,
  input  logic [DATA_W-1:0] i_op_b,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_product
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              w_last;

  // The step performed this cycle is the final one
  assign w_last = r_busy && (r_cnt == CNT_W'(DATA_W - 1));

  // Operand latch and one shift-add step per unfrozen cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_abort) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= i_op_a;
      r_mplier <= i_op_b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy && !i_freeze) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (w_last) begin
        r_cnt  <= '0;
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = w_last && !i_freeze;
  assign o_product = r_acc;

endmodule
`endif
`default_nettype wire

// File: rtl/exec_stage_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : exec_stage_mc                                                |
// | Description : Pipeline execute stage with operand forwarding, single-cycle |
// |               ALU and EX/MEM register. Optional iterative multiply with a  |
// |               stalling FSM, enabled by macro EXEC_STAGE_MUL_EN; without it |
// |               op 10 yields 0 in a single cycle and stall_o = hold_i.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module exec_stage_mc #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_rd_data1,
  input  logic [DATA_W-1:0]     id_rd_data2,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [4:0]            id_shamt,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_dst,
  input  logic                  id_alu_src,
  input  logic [3:0]            id_op,
  input  logic                  id_reg_wr,
  input  logic                  id_mem_wr,
  input  logic                  id_mem_rd,
  input  logic                  id_wb_sel,
  input  logic [1:0]            fwd_a_sel,
  input  logic [1:0]            fwd_b_sel,
  input  logic [DATA_W-1:0]     mem_fwd_data,
  input  logic [DATA_W-1:0]     wb_fwd_data,
  input  logic                  hold_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  exm_valid,
  output logic [DATA_W-1:0]     exm_alu_out,
  output logic [DATA_W-1:0]     exm_wr_data,
  output logic [REG_ADDR_W-1:0] exm_dest,
  output logic                  exm_reg_wr,
  output logic                  exm_mem_wr,
  output logic                  exm_mem_rd,
  output logic                  exm_wb_sel,
  output logic                  exm_ovf
);

  import exec_pkg::*;

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0]     w_fwd_a;
  logic [DATA_W-1:0]     w_fwd_b;
  logic [DATA_W-1:0]     w_op_b;
  logic [DATA_W-1:0]     w_sum;
  logic [DATA_W-1:0]     w_diff;
  logic [DATA_W-1:0]     w_alu_res;
  logic                  w_alu_ovf;
  logic [REG_ADDR_W-1:0] w_dest;

  logic                  w_exm_load;
  logic                  w_nx_valid;
  logic [DATA_W-1:0]     w_nx_alu_out;
  logic [DATA_W-1:0]     w_nx_wr_data;
  logic [REG_ADDR_W-1:0] w_nx_dest;
  logic                  w_nx_reg_wr;
  logic                  w_nx_mem_wr;
  logic                  w_nx_mem_rd;
  logic                  w_nx_wb_sel;
  logic                  w_nx_ovf;

  logic                  r_exm_valid;
  logic [DATA_W-1:0]     r_exm_alu_out;
  logic [DATA_W-1:0]     r_exm_wr_data;
  logic [REG_ADDR_W-1:0] r_exm_dest;
  logic                  r_exm_reg_wr;
  logic                  r_exm_mem_wr;
  logic                  r_exm_mem_rd;
  logic                  r_exm_wb_sel;
  logic                  r_exm_ovf;

  // Operand A forwarding mux
  always_comb begin
    case (fwd_a_sel)
      FWD_MEM: w_fwd_a = mem_fwd_data;
      FWD_WB:  w_fwd_a = wb_fwd_data;
      default: w_fwd_a = id_rd_data1;
    endcase
  end

  // Operand B forwarding mux
  always_comb begin
    case (fwd_b_sel)
      FWD_MEM: w_fwd_b = mem_fwd_data;
      FWD_WB:  w_fwd_b = wb_fwd_data;
      default: w_fwd_b = id_rd_data2;
    endcase
  end

  assign w_op_b = id_alu_src ? id_imm : w_fwd_b;
  assign w_dest = id_reg_dst ? id_rd : id_rt;
  assign w_sum  = w_fwd_a + w_op_b;
  assign w_diff = w_fwd_a - w_op_b;

  // Single-cycle ALU; shifts act on operand B (MIPS rt-style) by id_shamt
  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    case (id_op)
      OP_ADD: begin
        w_alu_res = w_sum;
        w_alu_ovf = (w_fwd_a[MSB] == w_op_b[MSB]) && (w_sum[MSB] != w_fwd_a[MSB]);
      end
      OP_SUB: begin
        w_alu_res = w_diff;
        w_alu_ovf = (w_fwd_a[MSB] != w_op_b[MSB]) && (w_diff[MSB] != w_fwd_a[MSB]);
      end
      OP_AND:  w_alu_res = w_fwd_a & w_op_b;
      OP_OR:   w_alu_res = w_fwd_a | w_op_b;
      OP_XOR:  w_alu_res = w_fwd_a ^ w_op_b;
      OP_NOR:  w_alu_res = ~(w_fwd_a | w_op_b);
      OP_SLT:  w_alu_res[0] = ($signed(w_fwd_a) < $signed(w_op_b));
      OP_SLL:  w_alu_res = w_op_b << id_shamt;
      OP_SRL:  w_alu_res = w_op_b >> id_shamt;
      OP_SRA:  w_alu_res = $unsigned($signed(w_op_b) >>> id_shamt);
      default: w_alu_res = '0;
    endcase
  end

`ifdef EXEC_STAGE_MUL_EN
  exec_state_t           r_state;
  logic                  w_mul_start;
  logic                  w_mul_busy;
  logic                  w_mul_done;
  logic [DATA_W-1:0]     w_mul_product;
  logic [DATA_W-1:0]     r_mul_wr_data;
  logic [REG_ADDR_W-1:0] r_mul_dest;
  logic                  r_mul_reg_wr;
  logic                  r_mul_mem_wr;
  logic                  r_mul_mem_rd;
  logic                  r_mul_wb_sel;

  // A MUL is accepted only from IDLE with no hold or flush this cycle
  assign w_mul_start = (r_state == ST_IDLE) && id_valid && (id_op == OP_MUL)
                       && !hold_i && !flush_i;
  assign stall_o     = hold_i || (r_state != ST_IDLE);

  exec_mul_iter #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_mul_start),
    .i_freeze  (hold_i),
    .i_abort   (flush_i),
    .i_op_a    (w_fwd_a),
    .i_op_b    (w_op_b),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );

  // Multiply sequencing: flush aborts, hold freezes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else if (flush_i) begin
      r_state <= ST_IDLE;
    end else if (!hold_i) begin
      case (r_state)
        ST_IDLE: begin
          if (w_mul_start) begin
            r_state <= ST_MUL_BUSY;
          end
        end
        ST_MUL_BUSY: begin
          if (w_mul_done) begin
            r_state <= ST_MUL_DONE;
          end else if (!w_mul_busy) begin
            // Multiplier lost its operation; recover rather than hang
            r_state <= ST_IDLE;
          end
        end
        ST_MUL_DONE: r_state <= ST_IDLE;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  // Capture the MUL's pass-through controls at acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mul_wr_data <= '0;
      r_mul_dest    <= '0;
      r_mul_reg_wr  <= 1'b0;
      r_mul_mem_wr  <= 1'b0;
      r_mul_mem_rd  <= 1'b0;
      r_mul_wb_sel  <= 1'b0;
    end else if (w_mul_start) begin
      r_mul_wr_data <= w_fwd_b;
      r_mul_dest    <= w_dest;
      r_mul_reg_wr  <= id_reg_wr;
      r_mul_mem_wr  <= id_mem_wr;
      r_mul_mem_rd  <= id_mem_rd;
      r_mul_wb_sel  <= id_wb_sel;
    end
  end
`else
  assign stall_o = hold_i;
`endif

  // Next EX/MEM contents; defaults describe a bubble
  always_comb begin
    w_exm_load   = 1'b1;
    w_nx_valid   = 1'b0;
    w_nx_alu_out = '0;
    w_nx_wr_data = '0;
    w_nx_dest    = '0;
    w_nx_reg_wr  = 1'b0;
    w_nx_mem_wr  = 1'b0;
    w_nx_mem_rd  = 1'b0;
    w_nx_wb_sel  = 1'b0;
    w_nx_ovf     = 1'b0;
    if (flush_i) begin
      w_exm_load = 1'b1;
    end else if (hold_i) begin
      w_exm_load = 1'b0;
`ifdef EXEC_STAGE_MUL_EN
    end else if (r_state == ST_MUL_BUSY) begin
      w_exm_load = 1'b1;
    end else if (r_state == ST_MUL_DONE) begin
      w_nx_valid   = 1'b1;
      w_nx_alu_out = w_mul_product;
      w_nx_wr_data = r_mul_wr_data;
      w_nx_dest    = r_mul_dest;
      w_nx_reg_wr  = r_mul_reg_wr;
      w_nx_mem_wr  = r_mul_mem_wr;
      w_nx_mem_rd  = r_mul_mem_rd;
      w_nx_wb_sel  = r_mul_wb_sel;
    end else if (id_valid && (id_op == OP_MUL)) begin
      // Accepted MUL leaves a bubble while it iterates
      w_exm_load = 1'b1;
`endif
    end else if (id_valid) begin
      w_nx_valid   = 1'b1;
      w_nx_alu_out = w_alu_res;
      w_nx_wr_data = w_fwd_b;
      w_nx_dest    = w_dest;
      w_nx_reg_wr  = id_reg_wr;
      w_nx_mem_wr  = id_mem_wr;
      w_nx_mem_rd  = id_mem_rd;
      w_nx_wb_sel  = id_wb_sel;
      w_nx_ovf     = w_alu_ovf;
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_exm_valid   <= 1'b0;
      r_exm_alu_out <= '0;
      r_exm_wr_data <= '0;
      r_exm_dest    <= '0;
      r_exm_reg_wr  <= 1'b0;
      r_exm_mem_wr  <= 1'b0;
      r_exm_mem_rd  <= 1'b0;
      r_exm_wb_sel  <= 1'b0;
      r_exm_ovf     <= 1'b0;
    end else if (w_exm_load) begin
      r_exm_valid   <= w_nx_valid;
      r_exm_alu_out <= w_nx_alu_out;
      r_exm_wr_data <= w_nx_wr_data;
      r_exm_dest    <= w_nx_dest;
      r_exm_reg_wr  <= w_nx_reg_wr;
      r_exm_mem_wr  <= w_nx_mem_wr;
      r_exm_mem_rd  <= w_nx_mem_rd;
      r_exm_wb_sel  <= w_nx_wb_sel;
      r_exm_ovf     <= w_nx_ovf;
    end
  end

  assign exm_valid   = r_exm_valid;
  assign exm_alu_out = r_exm_alu_out;
  assign exm_wr_data = r_exm_wr_data;
  assign exm_dest    = r_exm_dest;
  assign exm_reg_wr  = r_exm_reg_wr;
  assign exm_mem_wr  = r_exm_mem_wr;
  assign exm_mem_rd  = r_exm_mem_rd;
  assign exm_wb_sel  = r_exm_wb_sel;
  assign exm_ovf     = r_exm_ovf;

endmodule
`default_nettype wire

// File: tb/tb_exec_stage_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_exec_stage_mc                                             |
// | Description : Self-checking bench for exec_stage_mc (DATA_W=32) with a     |
// |               behavioural reference model; MUL paths follow the            |
// |               EXEC_STAGE_MUL_EN macro.                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_exec_stage_mc;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [DW-1:0] id_rd_data1, id_rd_data2, id_imm;
  logic [4:0]    id_shamt;
  logic [AW-1:0] id_rt, id_rd;
  logic          id_reg_dst, id_alu_src;
  logic [3:0]    id_op;
  logic          id_reg_wr, id_mem_wr, id_mem_rd, id_wb_sel;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic [DW-1:0] mem_fwd_data, wb_fwd_data;
  logic          hold_i, flush_i;
  logic          stall_o;
  logic          exm_valid;
  logic [DW-1:0] exm_alu_out, exm_wr_data;
  logic [AW-1:0] exm_dest;
  logic          exm_reg_wr, exm_mem_wr, exm_mem_rd, exm_wb_sel, exm_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: expected EX/MEM contents and pending multiply
  logic          m_valid, m_reg_wr, m_mem_wr, m_mem_rd, m_wb_sel, m_ovf;
  logic [DW-1:0] m_alu, m_wr;
  logic [AW-1:0] m_dest;
  int            m_left;
  logic [DW-1:0] m_prod, m_pwr;
  logic [AW-1:0] m_pdest;
  logic [3:0]    m_pctl;

  logic          n_valid, n_reg_wr, n_mem_wr, n_mem_rd, n_wb_sel, n_ovf;
  logic [DW-1:0] n_alu, n_wr;
  logic [AW-1:0] n_dest;
  int            n_left;
  logic [DW-1:0] n_prod, n_pwr;
  logic [AW-1:0] n_pdest;
  logic [3:0]    n_pctl;

  exec_stage_mc #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rd_data1(id_rd_data1), .id_rd_data2(id_rd_data2), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_rt(id_rt), .id_rd(id_rd), .id_reg_dst(id_reg_dst),
    .id_alu_src(id_alu_src), .id_op(id_op), .id_reg_wr(id_reg_wr),
    .id_mem_wr(id_mem_wr), .id_mem_rd(id_mem_rd), .id_wb_sel(id_wb_sel),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_data(wb_fwd_data), .hold_i(hold_i), .flush_i(flush_i),
    .stall_o(stall_o), .exm_valid(exm_valid), .exm_alu_out(exm_alu_out),
    .exm_wr_data(exm_wr_data), .exm_dest(exm_dest), .exm_reg_wr(exm_reg_wr),
    .exm_mem_wr(exm_mem_wr), .exm_mem_rd(exm_mem_rd), .exm_wb_sel(exm_wb_sel),
    .exm_ovf(exm_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU from the arithmetic definition of each op; returns {ovf, result}
  function automatic logic [DW:0] ref_alu(input logic [3:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b, input logic [4:0] sh);
    longint sa, sb, r;
    logic [DW-1:0] res;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 0;
    res = '0;
    ovf = 1'b0;
    case (op)
      4'd0: begin r = sa + sb; res = r[DW-1:0]; ovf = (r > MAXS) || (r < MINS); end
      4'd1: begin r = sa - sb; res = r[DW-1:0]; ovf = (r > MAXS) || (r < MINS); end
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      4'd5: res = ~(a | b);
      4'd6: res = (sa < sb) ? 32'd1 : 32'd0;
      4'd7: res = b << sh;
      4'd8: res = b >> sh;
      4'd9: begin r = sb >>> sh; res = r[DW-1:0]; end
      default: res = '0;
    endcase
    return {ovf, res};
  endfunction

  function automatic logic [DW-1:0] pick(input logic [1:0] sel, input logic [DW-1:0] regv);
    if (sel == 2'd1) return mem_fwd_data;
    if (sel == 2'd2) return wb_fwd_data;
    return regv;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_reg_wr = 0; m_mem_wr = 0; m_mem_rd = 0; m_wb_sel = 0; m_ovf = 0;
    m_alu = '0; m_wr = '0; m_dest = '0; m_left = 0;
    m_prod = '0; m_pwr = '0; m_pdest = '0; m_pctl = '0;
  endtask

  task automatic set_bubble();
    n_valid = 0; n_reg_wr = 0; n_mem_wr = 0; n_mem_rd = 0; n_wb_sel = 0; n_ovf = 0;
    n_alu = '0; n_wr = '0; n_dest = '0;
  endtask

  // Compute what EX/MEM must hold after the coming edge
  task automatic model_next();
    logic [DW-1:0] a, bf, b;
    logic [DW:0] r;
    n_valid = m_valid; n_reg_wr = m_reg_wr; n_mem_wr = m_mem_wr; n_mem_rd = m_mem_rd;
    n_wb_sel = m_wb_sel; n_ovf = m_ovf; n_alu = m_alu; n_wr = m_wr; n_dest = m_dest;
    n_left = m_left; n_prod = m_prod; n_pwr = m_pwr; n_pdest = m_pdest; n_pctl = m_pctl;
    a = pick(fwd_a_sel, id_rd_data1);
    bf = pick(fwd_b_sel, id_rd_data2);
    b = id_alu_src ? id_imm : bf;
    if (flush_i) begin
      set_bubble();
      n_left = 0;
    end else if (hold_i) begin
      n_left = m_left;
    end else if (m_left > 0) begin
      n_left = m_left - 1;
      if (n_left == 0) begin
        n_valid = 1; n_alu = m_prod; n_wr = m_pwr; n_dest = m_pdest; n_ovf = 0;
        {n_reg_wr, n_mem_wr, n_mem_rd, n_wb_sel} = m_pctl;
      end else begin
        set_bubble();
      end
    end else if (id_valid) begin
`ifdef EXEC_STAGE_MUL_EN
      if (id_op == 4'd10) begin
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        set_bubble();
        n_left = DW + 1;
        n_prod = p[DW-1:0];
        n_pwr = bf;
        n_pdest = id_reg_dst ? id_rd : id_rt;
        n_pctl = {id_reg_wr, id_mem_wr, id_mem_rd, id_wb_sel};
      end else begin
`endif
        r = ref_alu(id_op, a, b, id_shamt);
        n_valid = 1; n_alu = r[DW-1:0]; n_ovf = r[DW]; n_wr = bf;
        n_dest = id_reg_dst ? id_rd : id_rt;
        n_reg_wr = id_reg_wr; n_mem_wr = id_mem_wr; n_mem_rd = id_mem_rd; n_wb_sel = id_wb_sel;
`ifdef EXEC_STAGE_MUL_EN
      end
`endif
    end else begin
      set_bubble();
    end
  endtask

  task automatic model_commit();
    m_valid = n_valid; m_reg_wr = n_reg_wr; m_mem_wr = n_mem_wr; m_mem_rd = n_mem_rd;
    m_wb_sel = n_wb_sel; m_ovf = n_ovf; m_alu = n_alu; m_wr = n_wr; m_dest = n_dest;
    m_left = n_left; m_prod = n_prod; m_pwr = n_pwr; m_pdest = n_pdest; m_pctl = n_pctl;
  endtask

  // The single output checker, used every cycle
  task automatic compare_outputs();
    chk("exm_valid", exm_valid, m_valid);
    chk("exm_alu_out", exm_alu_out, m_alu);
    chk("exm_wr_data", exm_wr_data, m_wr);
    chk("exm_dest", exm_dest, m_dest);
    chk("exm_reg_wr", exm_reg_wr, m_reg_wr);
    chk("exm_mem_wr", exm_mem_wr, m_mem_wr);
    chk("exm_mem_rd", exm_mem_rd, m_mem_rd);
    chk("exm_wb_sel", exm_wb_sel, m_wb_sel);
    chk("exm_ovf", exm_ovf, m_ovf);
  endtask

  // One clock: check stall, advance model, check registered outputs after the edge
  task automatic cycle();
    #1;
    chk("stall_o", stall_o, hold_i | (m_left > 0));
    model_next();
    @(posedge clk);
    model_commit();
    #1;
    compare_outputs();
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [DW-1:0] imm,
                           input logic src);
    id_valid = 1; id_op = op; id_rd_data1 = a; id_rd_data2 = b; id_imm = imm;
    id_alu_src = src; id_shamt = 5'd0; fwd_a_sel = 2'd0; fwd_b_sel = 2'd0;
    id_rt = 5'd3; id_rd = 5'd7; id_reg_dst = 1; id_reg_wr = 1;
    id_mem_wr = 0; id_mem_rd = 0; id_wb_sel = 0;
  endtask

  task automatic randomize_inputs();
    logic [DW-1:0] corner [5];
    corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'h7FFF_FFFF;
    corner[3] = 32'h8000_0000; corner[4] = 32'hFFFF_FFFF;
    id_valid = ($urandom_range(0, 9) != 0);
    id_op = 4'($urandom_range(0, 15));
    id_rd_data1 = ($urandom_range(0, 5) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
    id_rd_data2 = ($urandom_range(0, 5) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
    id_imm = ($urandom_range(0, 5) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
    mem_fwd_data = $urandom;
    wb_fwd_data = $urandom;
    id_shamt = 5'($urandom_range(0, 31));
    id_rt = 5'($urandom_range(0, 31));
    id_rd = 5'($urandom_range(0, 31));
    id_reg_dst = 1'($urandom_range(0, 1));
    id_alu_src = 1'($urandom_range(0, 1));
    id_reg_wr = 1'($urandom_range(0, 1));
    id_mem_wr = 1'($urandom_range(0, 1));
    id_mem_rd = 1'($urandom_range(0, 1));
    id_wb_sel = 1'($urandom_range(0, 1));
    fwd_a_sel = 2'($urandom_range(0, 3));
    fwd_b_sel = 2'($urandom_range(0, 3));
    hold_i = ($urandom_range(0, 9) == 0);
    flush_i = ($urandom_range(0, 29) == 0);
  endtask

  initial begin
    int nv;
    reset = 1; hold_i = 0; flush_i = 0;
    set_instr(4'd0, '0, '0, '0, 0);
    id_valid = 0; mem_fwd_data = '0; wb_fwd_data = '0;
    model_reset();
    #2;
    compare_outputs();
    chk("reset stall_o hold0", stall_o, 1'b0);
    hold_i = 1; #1;
    chk("reset stall_o hold1", stall_o, 1'b1);
    hold_i = 0;
    @(posedge clk); #1;
    compare_outputs();
    reset = 0;

    // ADD overflow wrap
    set_instr(4'd0, 32'h7FFF_FFFF, 32'h0, 32'h1, 1);
    cycle();
    chk("add_ovf alu_out", exm_alu_out, 32'h8000_0000);
    chk("add_ovf ovf", exm_ovf, 1'b1);
    chk("add_ovf valid", exm_valid, 1'b1);

    // SUB with forwarded A and immediate B
    set_instr(4'd1, 32'd100, 32'd9, 32'd3, 1);
    fwd_a_sel = 2'd1; mem_fwd_data = 32'd5;
    cycle();
    chk("sub_fwd alu_out", exm_alu_out, 32'd2);
    chk("sub_fwd wr_data", exm_wr_data, 32'd9);
    chk("sub_fwd ovf", exm_ovf, 1'b0);

    // Hold for three cycles across an SLT
    set_instr(4'd0, 32'd1, 32'd1, 32'd0, 0);
    cycle();
    chk("pre_hold alu_out", exm_alu_out, 32'd2);
    set_instr(4'd6, 32'hFFFF_FFFB, 32'd2, 32'd0, 0);
    hold_i = 1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("hold frozen alu_out", exm_alu_out, 32'd2);
    end
    hold_i = 0;
    cycle();
    chk("slt alu_out", exm_alu_out, 32'd1);
    chk("slt valid", exm_valid, 1'b1);
    id_valid = 0;
    cycle();

`ifdef EXEC_STAGE_MUL_EN
    // MUL 7 x -3
    set_instr(4'd10, 32'd7, 32'hFFFF_FFFD, 32'd0, 0);
    cycle();
    nv = 0;
    while (stall_o && nv < 100) begin
      nv++;
      cycle();
    end
    id_valid = 0;
    chk("mul stall cycles", nv, 33);
    chk("mul alu_out", exm_alu_out, 32'hFFFF_FFEB);
    chk("mul valid", exm_valid, 1'b1);
    cycle();

    // Flush during the tenth busy cycle
    set_instr(4'd10, 32'd7, 32'd9, 32'd0, 0);
    cycle();
    repeat (9) cycle();
    flush_i = 1;
    cycle();
    flush_i = 0; id_valid = 0;
    #1;
    chk("flush stall_o", stall_o, 1'b0);
    nv = 0;
    repeat (40) begin
      cycle();
      if (exm_valid) nv++;
    end
    chk("flush no result", nv, 0);

    // Reset in the middle of a multiply
    set_instr(4'd10, 32'd11, 32'd13, 32'd0, 0);
    cycle();
    repeat (5) cycle();
    #2;
    reset = 1;
    #1;
    model_reset();
    compare_outputs();
    chk("reset_mid stall_o", stall_o, 1'b0);
    @(posedge clk); #1;
    reset = 0; id_valid = 0;
    nv = 0;
    repeat (40) begin
      cycle();
      if (exm_valid) nv++;
    end
    chk("reset_mid no result", nv, 0);
`else
    // Op 10 without multiply support: single-cycle zero
    set_instr(4'd10, 32'd7, 32'hFFFF_FFFD, 32'd0, 0);
    #1;
    chk("mul_off stall_o", stall_o, 1'b0);
    cycle();
    chk("mul_off alu_out", exm_alu_out, 32'd0);
    chk("mul_off valid", exm_valid, 1'b1);
    // Asynchronous reset clears outputs without a clock edge
    set_instr(4'd3, 32'h0F0F_0000, 32'h0000_F0F0, 32'd0, 0);
    cycle();
    chk("or alu_out", exm_alu_out, 32'h0F0F_F0F0);
    #2;
    reset = 1;
    #1;
    model_reset();
    compare_outputs();
    chk("async reset alu_out", exm_alu_out, 32'd0);
    @(posedge clk); #1;
    reset = 0; id_valid = 0;
    cycle();
`endif

    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exec_stage_mc.md
EXEC_STAGE_MC -- requirements
Module: exec_stage_mc

Interface
REQ-001 Parameter DATA_W, default 32: datapath width in bits; legal values 16..64.
REQ-002 Parameter REG_ADDR_W, default 5: register-index width.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Ports id_valid, input, 1, and id_rd_data1/id_rd_data2, input, DATA_W each: ID/EX instruction valid and register operands.
REQ-006 Ports id_imm, input, DATA_W, and id_shamt, input, 5: sign-extended immediate and shift amount.
REQ-007 Ports id_rt/id_rd, input, REG_ADDR_W each, and id_reg_dst, input, 1: destination select (0 = rt, 1 = rd).
REQ-008 Ports id_alu_src, input, 1, and id_op, input, 4: immediate select for operand B and ALU operation code.
REQ-009 Ports id_reg_wr/id_mem_wr/id_mem_rd/id_wb_sel, input, 1 each: control bits passed through.
REQ-010 Ports fwd_a_sel/fwd_b_sel, input, 2 each, plus mem_fwd_data/wb_fwd_data, input, DATA_W each: forwarding selects and sources.
REQ-011 Ports hold_i and flush_i, input, 1 each: downstream hold and pipeline flush.
REQ-012 Port stall_o, output, 1: upstream must not advance the ID/EX register.
REQ-013 Ports exm_valid, exm_alu_out, exm_wr_data, exm_dest, exm_reg_wr, exm_mem_wr, exm_mem_rd, exm_wb_sel, output, registered: EX/MEM register.
REQ-014 Port exm_ovf, output, 1: registered signed-overflow flag.

Function
REQ-015 Forward select 0/1/2/3 SHALL pick register data / mem_fwd_data / wb_fwd_data / register data, independently per operand.
REQ-016 Operand B = id_imm when id_alu_src=1, else forwarded B; exm_wr_data = forwarded B.
REQ-017 Ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed, result 0/1), 7 SLL, 8 SRL, 9 SRA (by id_shamt), 10 MUL; 11-15 yield 0.
REQ-018 ADD/SUB wrap modulo 2^DATA_W; ovf = signed overflow for ADD/SUB only, else 0.
REQ-019 Single-cycle ops: result in EX/MEM one cycle after acceptance (id_valid=1, stall_o=0).
REQ-020 FSM states IDLE, MUL_BUSY, MUL_DONE; reset state IDLE.
REQ-021 IDLE -> MUL_BUSY when MUL accepted; operands and controls latched that edge.
REQ-022 MUL_BUSY: shift-add, one bit per cycle, DATA_W cycles, then MUL_DONE; result = low DATA_W bits of product.
REQ-023 MUL_DONE: result and latched controls loaded into EX/MEM with exm_valid=1; return to IDLE.
REQ-024 stall_o = 1 in MUL_BUSY and MUL_DONE, or whenever hold_i=1; MUL latency = DATA_W+2 cycles.
REQ-025 During MUL_BUSY, EX/MEM SHALL load a bubble (exm_valid=0, all write enables 0).
REQ-026 hold_i=1: EX/MEM and FSM hold their values; MUL counter frozen.
REQ-027 flush_i=1: next edge loads bubble and forces FSM to IDLE, aborting any MUL; flush beats hold.
REQ-028 id_valid=0 while IDLE loads a bubble.

Reset
REQ-029 reset SHALL immediately clear all EX/MEM outputs, exm_ovf and the MUL counter to 0 and set FSM to IDLE; stall_o follows hold_i only.
REQ-030 Reset asserted mid-multiply discards the operation; no result is ever emitted for it.

Configuration
REQ-031 Macro EXEC_STAGE_MUL_EN defined: MUL support per REQ-020..025.
REQ-032 Without it: op 10 yields 0 single-cycle, FSM and multiplier absent, stall_o = hold_i.

Structure
REQ-033 Shared package exec_pkg SHALL hold the 4-bit op-code constants, forward-select constants and FSM state type.
REQ-034 Multiplier SHALL be sub-module exec_mul_iter (start, operands, busy, done, product).

Verification
REQ-035 ADD 0x7FFFFFFF + 1 (DATA_W=32) -> exm_alu_out 0x80000000, exm_ovf=1, one cycle later.
REQ-036 fwd_a_sel=1, mem_fwd_data=5, SUB with imm 3 -> exm_alu_out 2.
REQ-037 MUL 7 x -3 -> stall_o high 33 cycles, bubbles, then exm_alu_out 0xFFFFFFEB, exm_valid=1.
REQ-038 flush_i at MUL_BUSY cycle 10 -> FSM IDLE, no MUL result, stall_o drops next cycle.
REQ-039 hold_i 3 cycles during SLT -5<2 -> EX/MEM frozen, then result 1.
REQ-040 reset mid-MUL -> all outputs 0 immediately, no result after release.
